// File: rtl/ecc_pkg.sv
// Shared definitions for the SECDED core: op/width/error codes, code geometry per width,
// the H-matrix data columns and the controller state encoding.
package ecc_pkg;

  localparam logic [1:0] OP_ENC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_FULL = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  localparam logic [1:0] WC_8  = 2'b00;
  localparam logic [1:0] WC_16 = 2'b01;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_SINGLE = 2'b01;
  localparam logic [1:0] ERR_DOUBLE = 2'b10;

  localparam logic [5:0] N_8  = 6'd8;  localparam logic [5:0] K_8  = 6'd4;  localparam logic [5:0] P_8  = 6'd3;
  localparam logic [5:0] N_16 = 6'd16; localparam logic [5:0] K_16 = 6'd11; localparam logic [5:0] P_16 = 6'd4;
  localparam logic [5:0] N_32 = 6'd32; localparam logic [5:0] K_32 = 6'd26; localparam logic [5:0] P_32 = 6'd5;

  localparam int MAX_K = 26;

  // Column of data bit i: the i-th integer >= 3 that is not a power of two.
  localparam logic [4:0] H_COL [0:MAX_K-1] = '{
    5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13,
    5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
    5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31
  };

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_ENCODE, ST_CHANNEL, ST_DECODE, ST_DONE
  } state_e;

  function automatic logic [5:0] n_of(input logic [1:0] wc);
    case (wc)
      WC_8:    return N_8;
      WC_16:   return N_16;
      default: return N_32;
    endcase
  endfunction

  function automatic logic [5:0] k_of(input logic [1:0] wc);
    case (wc)
      WC_8:    return K_8;
      WC_16:   return K_16;
      default: return K_32;
    endcase
  endfunction

  function automatic logic [5:0] p_of(input logic [1:0] wc);
    case (wc)
      WC_8:    return P_8;
      WC_16:   return P_16;
      default: return P_32;
    endcase
  endfunction

endpackage

// File: rtl/ecc_hamming_calc.sv
// Combinational SECDED arithmetic for one width code: builds the codeword from the data
// bits of word_i, and decodes word_i as a received codeword (correction + error class).
module ecc_hamming_calc
  import ecc_pkg::*;
(
  input  logic [1:0]  wc_i,
  input  logic [31:0] word_i,
  output logic [31:0] codeword_o,
  output logic [31:0] data_o,
  output logic [1:0]  err_o
);

  logic [5:0]  n, k, np;
  logic [31:0] dmask, nmask, dat, flip;
  logic [4:0]  pmask, par, recv, syn;
  logic        q, ovr;

  always_comb begin
    n     = n_of(wc_i);
    k     = k_of(wc_i);
    np    = p_of(wc_i);
    dmask = (32'd1 << k) - 32'd1;
    nmask = (32'd1 << n) - 32'd1;
    pmask = (5'd1 << np) - 5'd1;
    dat   = word_i & dmask;

    par = '0;
    for (int i = 0; i < MAX_K; i++) begin
      if (dat[i]) par = par ^ H_COL[i];
    end
    par  = par & pmask;
    recv = 5'(word_i >> k) & pmask;
    syn  = par ^ recv;
    q    = ^(word_i & nmask);
    ovr  = (^dat) ^ (^par);

    codeword_o = dat | (32'(par) << k) | (32'(ovr) << (n - 6'd1));

    // Columns beyond K exceed the syndrome range for that width, so no per-width guard.
    flip = '0;
    for (int i = 0; i < MAX_K; i++) begin
      if (H_COL[i] == syn) flip[i] = 1'b1;
    end

    if (q) begin
      data_o = dat ^ flip;
      err_o  = ERR_SINGLE;
    end else if (syn != 5'd0) begin
      data_o = dat;
      err_o  = ERR_DOUBLE;
    end else begin
      data_o = dat;
      err_o  = ERR_NONE;
    end
  end

endmodule

// File: rtl/ecc_enc_dec_core.sv
// SECDED encode / decode / full-channel engine started by a snooped APB CTRL write.
// Results and done pulse 2 edges after the write (4 for full channel); no backpressure.
module ecc_enc_dec_core
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       CTRL,
  input  logic [AMBA_WORD-1:0]       DATA_IN,
  input  logic [AMBA_WORD-1:0]       CODEWORD_WIDTH,
  input  logic [AMBA_WORD-1:0]       NOISE,
  output logic [AMBA_WORD-1:0]       data_out,
  output logic                       operation_done,
  output logic [1:0]                 num_of_errors
);

  state_e      state_q, state_d;
  logic [1:0]  op_q, wc_q, err_q;
  logic [31:0] work_q, noise_q, data_q;
  logic        done_q, ill_q;
  logic        start;
  logic [31:0] calc_cw, calc_data;
  logic [1:0]  calc_err;
  logic        unused_bits;

  assign start = PSEL & PENABLE & PWRITE & (PADDR[3:2] == 2'b00);
  assign unused_bits = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2],
                         PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0]};

  ecc_hamming_calc u_calc (
    .wc_i       (wc_q),
    .word_i     (work_q),
    .codeword_o (calc_cw),
    .data_o     (calc_data),
    .err_o      (calc_err)
  );

  // An illegal op spends a second cycle in WAIT so its done pulse lines up with encode/decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_WAIT;
      ST_WAIT: begin
        if (ill_q) state_d = ST_DONE;
        else begin
          case (CTRL[1:0])
            OP_DEC:  state_d = ST_DECODE;
            OP_ILL:  state_d = ST_WAIT;
            default: state_d = ST_ENCODE;
          endcase
        end
      end
      ST_ENCODE:  state_d = (op_q == OP_FULL) ? ST_CHANNEL : ST_DONE;
      ST_CHANNEL: state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_DONE;
      ST_DONE:    state_d = start ? ST_WAIT : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      wc_q    <= '0;
      work_q  <= '0;
      noise_q <= '0;
      data_q  <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == ST_DONE);
      ill_q   <= (state_q == ST_WAIT) && !ill_q && (CTRL[1:0] == OP_ILL);
      case (state_q)
        ST_WAIT: begin
          if (!ill_q) begin
            op_q    <= CTRL[1:0];
            wc_q    <= CODEWORD_WIDTH[1:0];
            work_q  <= DATA_IN[31:0];
            noise_q <= NOISE[31:0];
          end
        end
        ST_ENCODE: begin
          work_q <= calc_cw;
          if (op_q == OP_ENC) begin
            data_q <= calc_cw;
            err_q  <= ERR_NONE;
          end
        end
        // Noise bits above N land outside the decoded field and are ignored there.
        ST_CHANNEL: work_q <= work_q ^ noise_q;
        ST_DECODE: begin
          data_q <= calc_data;
          err_q  <= calc_err;
        end
        default: ;
      endcase
    end
  end

  assign data_out       = AMBA_WORD'(data_q);
  assign num_of_errors  = err_q;
  assign operation_done = done_q;

endmodule

// File: tb/tb_ecc_enc_dec_core.sv
// Randomized bench for ecc_enc_dec_core against a SECDED reference model built from
// the code definition (column enumeration, brute parity), plus pinned literal cases.
module tb_ecc_enc_dec_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] PADDR = '0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] CTRL = '0, DATA_IN = '0, CODEWORD_WIDTH = '0, NOISE = '0;
  logic [31:0] data_out;
  logic        operation_done;
  logic [1:0]  num_of_errors;

  ecc_enc_dec_core #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) dut (
    .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .CTRL(CTRL), .DATA_IN(DATA_IN), .CODEWORD_WIDTH(CODEWORD_WIDTH), .NOISE(NOISE),
    .data_out(data_out), .operation_done(operation_done), .num_of_errors(num_of_errors)
  );

  always #5 clk = ~clk;

  typedef struct { int at; bit ill; logic [31:0] d; logic [1:0] e; } exp_t;
  exp_t        expq[$];
  int          cyc = 0, vectors = 0, errors = 0;
  int          busy_edge = -100, prev_e0 = -100;
  logic [31:0] md = '0;
  logic [1:0]  me = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic int nbits(input logic [1:0] wc);
    return (wc == 2'd0) ? 8 : (wc == 2'd1) ? 16 : 32;
  endfunction
  function automatic int kbits(input logic [1:0] wc);
    return (wc == 2'd0) ? 4 : (wc == 2'd1) ? 11 : 26;
  endfunction
  function automatic logic [31:0] nmask(input logic [1:0] wc);
    int n = nbits(wc);
    return (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction
  function automatic int col(input int i);
    int v = 2, cnt = -1;
    while (cnt < i) begin
      v++;
      if ((v & (v - 1)) != 0) cnt++;
    end
    return v;
  endfunction
  function automatic logic [31:0] m_encode(input logic [1:0] wc, input logic [31:0] d);
    int n = nbits(wc), k = kbits(wc), p = n - 1 - k, par = 0;
    logic [31:0] cw = '0;
    for (int i = 0; i < k; i++) if (d[i]) begin cw[i] = 1'b1; par = par ^ col(i); end
    for (int j = 0; j < p; j++) cw[k+j] = par[j];
    cw[n-1] = ^cw;
    return cw;
  endfunction
  function automatic void m_decode(input logic [1:0] wc, input logic [31:0] r,
                                   output logic [31:0] d, output logic [1:0] e);
    int k = kbits(wc), p = nbits(wc) - 1 - k, s;
    logic [31:0] rr = r & nmask(wc);
    d = rr & ((32'd1 << k) - 32'd1);
    s = int'(((m_encode(wc, d) ^ rr) >> k) & ((32'd1 << p) - 32'd1));
    if (^rr) begin
      e = 2'd1;
      for (int i = 0; i < k; i++) if (col(i) == s) d[i] = ~d[i];
    end else e = (s != 0) ? 2'd2 : 2'd0;
  endfunction
  function automatic logic [31:0] rand_mask(input logic [1:0] wc, input int nf);
    logic [31:0] m = '0;
    int b;
    if (nf >= 3) return $urandom & nmask(wc);
    for (int i = 0; i < nf; i++) begin
      do b = int'($urandom_range(0, nbits(wc) - 1)); while (m[b]);
      m[b] = 1'b1;
    end
    return m;
  endfunction

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    logic        ed;
    logic [31:0] xd;
    logic [1:0]  xe;
    ed = 1'b0;
    if (!rst) begin
      xd = '0; xe = '0;
    end else begin
      if (expq.size() > 0 && expq[0].at == cyc) begin
        ed = 1'b1;
        if (!expq[0].ill) begin md = expq[0].d; me = expq[0].e; end
        void'(expq.pop_front());
      end
      xd = md; xe = me;
    end
    vectors++;
    if (operation_done !== ed || data_out !== xd || num_of_errors !== xe) begin
      errors++;
      $display("FAIL cycle %0d: done=%b data_out=%h errs=%b, expected done=%b data_out=%h errs=%b",
               cyc, operation_done, data_out, num_of_errors, ed, xd, xe);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Background bus/register traffic that must never launch an operation.
  task automatic noise_bus(input bit force_start);
    bit as, ar;
    as = (cyc + 1 >= prev_e0 + 1) && (cyc + 1 <= busy_edge);
    ar = (cyc + 1 >= prev_e0 + 2);
    PSEL = 1'($urandom); PENABLE = 1'($urandom); PWRITE = 1'($urandom);
    PADDR = 20'($urandom);
    if (!as) PADDR[3:2] = 2'($urandom_range(1, 3));
    else if (force_start) begin PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR[3:2] = 2'b00; end
    if (ar) begin
      CTRL = $urandom; DATA_IN = $urandom; CODEWORD_WIDTH = $urandom; NOISE = $urandom;
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [1:0] wc,
                          input logic [31:0] din, input logic [31:0] nz, input int gap);
    exp_t x;
    int   e0, lat;
    e0 = busy_edge + 1 + gap;
    while (cyc + 1 < e0) begin noise_bus(1'b0); tick(); end
    e0 = cyc + 1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
    PADDR = 20'($urandom); PADDR[3:2] = 2'b00;
    CTRL = $urandom; CTRL[1:0] = op;
    CODEWORD_WIDTH = $urandom; CODEWORD_WIDTH[1:0] = wc;
    DATA_IN = din; NOISE = nz;
    lat = (op == 2'd2) ? 4 : 2;
    x.at = e0 + lat; x.ill = (op == 2'd3); x.d = '0; x.e = '0;
    case (op)
      2'd0: x.d = m_encode(wc, din);
      2'd1: m_decode(wc, din, x.d, x.e);
      2'd2: m_decode(wc, m_encode(wc, din) ^ nz, x.d, x.e);
      default: ;
    endcase
    expq.push_back(x);
    prev_e0 = e0; busy_edge = e0 + lat;
    tick();
  endtask

  task automatic expect_lit(input string name, input logic [31:0] d, input logic [1:0] e,
                            input int lat, input bit force_start);
    int n = 0;
    while (!operation_done && n < 10) begin noise_bus(force_start); tick(); n++; end
    vectors++;
    if (!operation_done || cyc != prev_e0 + lat || data_out !== d || num_of_errors !== e) begin
      errors++;
      $display("FAIL %s: done=%b at edge+%0d data_out=%h errs=%b, expected done at edge+%0d data_out=%h errs=%b",
               name, operation_done, cyc - prev_e0, data_out, num_of_errors, lat, d, e);
    end
  endtask

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, %0d expectations pending", expq.size());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    logic [31:0] d, din, nz, pay;
    logic [1:0]  e, op, wc;
    int          r, nflip, n;

    // Pin the model to hand-computed values.
    chk("model_enc8_1", m_encode(2'd0, 32'h1), 32'hB1);
    chk("model_enc16_0", m_encode(2'd1, 32'h0), 32'h0);
    chk("model_col_first", 32'(col(0)), 32'd3);
    chk("model_col_last", 32'(col(25)), 32'd31);
    m_decode(2'd0, 32'hB0, d, e);
    chk("model_dec8_single", {d[29:0], e}, {30'h1, 2'd1});
    m_decode(2'd0, 32'hB2, d, e);
    chk("model_dec8_double", {d[29:0], e}, {30'h2, 2'd2});

    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();

    start_op(2'd0, 2'd0, 32'h1, 32'h0, 1);           expect_lit("enc8_one", 32'hB1, 2'd0, 2, 1'b0);
    start_op(2'd1, 2'd0, 32'hB0, 32'h0, 0);          expect_lit("dec8_single", 32'h1, 2'd1, 2, 1'b0);
    start_op(2'd1, 2'd0, 32'hFFFF_FFB2, 32'h0, 2);   expect_lit("dec8_double", 32'h2, 2'd2, 2, 1'b0);
    start_op(2'd2, 2'd2, 32'h0, 32'h0, 0);           expect_lit("full32_clean", 32'h0, 2'd0, 4, 1'b0);
    start_op(2'd2, 2'd3, 32'h0, 32'h8000_0000, 0);   expect_lit("full32_overall", 32'h0, 2'd1, 4, 1'b0);
    start_op(2'd0, 2'd1, 32'h0, 32'h0, 1);           expect_lit("enc16_zero_busy_start", 32'h0, 2'd0, 2, 1'b1);
    start_op(2'd0, 2'd0, 32'hFFFF_FFF1, 32'h0, 0);   expect_lit("enc8_back_to_back", 32'hB1, 2'd0, 2, 1'b0);

    // Abort a full-channel op while it sits in CHANNEL.
    start_op(2'd2, 2'd2, 32'h0123_4567, 32'h0, 0);
    noise_bus(1'b0); tick();
    noise_bus(1'b0); tick();
    rst = 1'b0;
    expq.delete(); md = '0; me = '0; busy_edge = cyc; prev_e0 = -100;
    #1;
    chk("async_reset_outputs", {data_out[28:0], num_of_errors, operation_done}, 32'h0);
    tick();
    repeat (2) begin noise_bus(1'b0); tick(); end
    rst = 1'b1;
    repeat (3) begin noise_bus(1'b0); tick(); end
    start_op(2'd3, 2'd2, 32'hDEAD_BEEF, 32'h0, 0);   expect_lit("illegal_after_reset", 32'h0, 2'd0, 2, 1'b0);

    for (int t = 0; t < 250; t++) begin
      r  = int'($urandom_range(0, 9));
      op = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      wc = 2'($urandom);
      pay = $urandom;
      nflip = int'($urandom_range(0, 3));
      din = pay; nz = $urandom;
      if (op == 2'd1) din = (m_encode(wc, pay) ^ rand_mask(wc, nflip)) | ($urandom & ~nmask(wc));
      if (op == 2'd2) nz = rand_mask(wc, nflip) | ($urandom & ~nmask(wc));
      start_op(op, wc, din, nz, int'($urandom_range(0, 3)));
    end

    n = 0;
    while (expq.size() != 0 && n < 20) begin noise_bus(1'b0); tick(); n++; end
    repeat (3) begin noise_bus(1'b0); tick(); end
    vectors++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d operations never completed, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
